// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: E-stage controller <-> multiply/divide unit signal bundle.
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic        cancel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (
        output start, md_op, cancel, rs_data, rt_data,
        input  busy, md_stall, hi, lo
    );
    modport slave (
        input  start, md_op, cancel, rs_data, rt_data,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: E-stage multiply/divide unit owning HI/LO; results are computed
// at acceptance and committed after a fixed-latency busy window.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] count;
    logic [31:0]   sh_hi, sh_lo, hi_q, lo_q;
    logic          sh_dz, accept, md_start, last, is_div, sgn, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
    logic [63:0]   prod, res;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    always_comb state_nx = (state == IDLE) ? (md_start ? RUN : IDLE) : (last ? IDLE : RUN);
    always_comb begin
        accept       = bus.start & ~bus.cancel & (state == IDLE);
        md_start     = accept & ~bus.md_op[2];
        last         = (state == RUN) & (count == CW'(1));
        bus.busy     = state == RUN;
        bus.md_stall = (state == RUN) | (bus.start & ~bus.cancel & ~bus.md_op[2]);
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end
    // Signed divide goes through magnitudes so 8000_0000 / -1 yields 8000_0000 rem 0
    always_comb begin
        is_div = bus.md_op[1];
        sgn    = ~bus.md_op[0];
        a_neg  = sgn & bus.rs_data[31];
        b_neg  = sgn & bus.rt_data[31];
        a_mag  = a_neg ? -bus.rs_data : bus.rs_data;
        b_mag  = b_neg ? -bus.rt_data : bus.rt_data;
        b_div  = (b_mag == '0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
        prod   = sgn ? {{32{bus.rs_data[31]}}, bus.rs_data} * {{32{bus.rt_data[31]}}, bus.rt_data}
                     : {32'b0, bus.rs_data} * {32'b0, bus.rt_data};
        res    = is_div ? {rem, quo} : prod;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            count <= '0;
            sh_hi <= '0;
            sh_lo <= '0;
            sh_dz <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (md_start) begin
                count          <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                {sh_hi, sh_lo} <= res;
                sh_dz          <= is_div & (bus.rt_data == '0);
            end else if (state == RUN) count <= count - CW'(1);
            if (last & ~sh_dz) begin
                hi_q <= sh_hi;
                lo_q <= sh_lo;
            end
            if (accept & (bus.md_op == 3'd4)) hi_q <= bus.rs_data;
            if (accept & (bus.md_op == 3'd5)) lo_q <= bus.rs_data;
        end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit, checked every cycle against
// a time-stamped behavioural model plus hand-computed literals.
module tb_mul_div_unit;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;
    mul_div_unit_if bus();
    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
    int nchk = 0, nfail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        calc = '0;
        if (op == 3'd0) calc = sa * sb;
        else if (op == 3'd1) calc = {32'b0, a} * {32'b0, b};
        else if (b != 0 && op == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
            calc = {r[31:0], q[31:0]};
        end else if (b != 0) calc = {a % b, a / b};
    endfunction
    // Model: an accepted mult/div completes at edge number accept_edge + latency
    int          cyc, done_at;
    logic        m_busy, p_dz;
    logic [31:0] m_hi, m_lo;
    logic [63:0] p_res;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0;
            m_hi = '0;
            m_lo = '0;
            cyc = 0;
        end else begin
            cyc++;
            if (m_busy) begin
                if (cyc == done_at) begin
                    m_busy = 1'b0;
                    if (!p_dz) {m_hi, m_lo} = p_res;
                end
            end else if (bus.start && !bus.cancel) begin
                if (bus.md_op <= 3'd3) begin
                    m_busy = 1'b1;
                    done_at = cyc + ((bus.md_op >= 3'd2) ? 10 : 5);
                    p_res = calc(bus.md_op, bus.rs_data, bus.rt_data);
                    p_dz = (bus.md_op >= 3'd2) && (bus.rt_data == 0);
                end else if (bus.md_op == 3'd4) m_hi = bus.rs_data;
                else if (bus.md_op == 3'd5) m_lo = bus.rs_data;
            end
        end
    end
    always @(negedge clk) if (reset) begin
        check("busy", {31'b0, bus.busy}, {31'b0, m_busy});
        check("md_stall", {31'b0, bus.md_stall},
              {31'b0, m_busy | (bus.start & ~bus.cancel & (bus.md_op <= 3'd3))});
        check("hi", bus.hi, m_hi);
        check("lo", bus.lo, m_lo);
    end
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.md_op = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.cancel = c;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
    endtask
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        check("busy_fall", {31'b0, bus.busy}, 32'd0);
    endtask
    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int cycles, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        issue(op, a, b, 1'b0);
        wait_idle(n);
        check({name, "_cycles"}, n, cycles);
        check({name, "_hi"}, bus.hi, ehi);
        check({name, "_lo"}, bus.lo, elo);
    endtask
    initial begin
        int n;
        bus.start = 1'b0;
        bus.md_op = 3'd7;
        bus.cancel = 1'b0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        #1 reset = 1'b1;
        run("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run("mult_big", 3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'd0);
        issue(3'd4, 32'h11, 32'd0, 1'b0);
        issue(3'd5, 32'h22, 32'd0, 1'b0);
        check("mt_hi", bus.hi, 32'h11);
        check("mt_lo", bus.lo, 32'h22);
        run("divz", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        issue(3'd4, 32'hABCD_0123, 32'd0, 1'b0);
        check("mthi_hi", bus.hi, 32'hABCD_0123);
        check("mthi_lo", bus.lo, 32'h22);
        check("mthi_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        check("mthi_busy2", {31'b0, bus.busy}, 32'd0);
        issue(3'd0, 32'd5, 32'd6, 1'b1);
        issue(3'd5, 32'h5555_5555, 32'd0, 1'b1);
        issue(3'd6, 32'd1, 32'd2, 1'b0);
        issue(3'd7, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        check("cancel_busy", {31'b0, bus.busy}, 32'd0);
        check("cancel_hi", bus.hi, 32'hABCD_0123);
        check("cancel_lo", bus.lo, 32'h22);
        issue(3'd0, 32'd3, 32'd4, 1'b0);
        issue(3'd1, 32'd9, 32'd9, 1'b0);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        wait_idle(n);
        check("ignored_hi", bus.hi, 32'd0);
        check("ignored_lo", bus.lo, 32'd12);
        issue(3'd2, 32'd100, 32'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        check("midrst_stall", {31'b0, bus.md_stall}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (12) @(negedge clk);
        check("postrst_lo", bus.lo, 32'd0);
        run("mult_after", 3'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule
